// File: rtl/umax_pkg.sv
// Shared types and default sizes for the stream max/min reducer.
// Optional build macro UMAX_REDUCER_MIN_EN selects minimum instead of maximum.
package umax_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int IDX_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } red_state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] max;
    logic [IDX_W_DEF-1:0] idx;
    logic [IDX_W_DEF-1:0] count;
    logic                 ovf;
  } red_result_t;

endpackage

// File: rtl/umax_cmp.sv
// Combinational MSB-first prefix comparator: gt_o says a_i wins over b_i.
// With UMAX_REDUCER_MIN_EN the operands are swapped so the smaller value wins.
module umax_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic [WIDTH-1:0] sel_val_o
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

`ifdef UMAX_REDUCER_MIN_EN
  assign x = b_i;
  assign y = a_i;
`else
  assign x = a_i;
  assign y = b_i;
`endif

  // The highest differing bit decides; equal operands never win.
  always_comb begin
    logic decided;
    gt_o    = 1'b0;
    decided = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (x[i] != y[i])) begin
        gt_o    = x[i];
        decided = 1'b1;
      end
    end
  end

  assign sel_val_o = gt_o ? a_i : b_i;

endmodule

// File: rtl/stream_umax_reducer.sv
// Reduces each input frame to its max word, first index of the max and beat count.
// Build macro UMAX_REDUCER_MIN_EN (in umax_cmp) turns it into a minimum reducer.
module stream_umax_reducer
  import umax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  red_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] best_q, best_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [IDX_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [IDX_W-1:0] cnt_inc;
  logic             cmp_gt;
  logic [WIDTH-1:0] cmp_val;

  umax_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i      (in_data),
    .b_i      (acc_q),
    .gt_o     (cmp_gt),
    .sel_val_o(cmp_val)
  );

  assign in_ready  = rst_n && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_max   = res_max_q;
  assign out_idx   = res_idx_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign cnt_inc  = cnt_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    best_d    = best_q;
    cnt_d     = cnt_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d     = in_data;
          best_d    = '0;
          cnt_d     = '0;
          res_ovf_d = 1'b0;
          state_d   = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          cnt_d = cnt_inc;
          if (cmp_gt) begin
            acc_d  = cmp_val;
            best_d = cnt_inc;
          end
          // A full counter closes the frame; flag it only if the source did not.
          if (in_last || (cnt_inc == '1)) begin
            state_d   = HOLD;
            res_ovf_d = ~in_last;
          end
        end
      end
      HOLD: begin
        if (out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    res_cnt_d = res_cnt_q;
    if ((state_q != HOLD) && (state_d == HOLD)) begin
      res_max_d = acc_d;
      res_idx_d = best_d;
      res_cnt_d = cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      best_q    <= '0;
      cnt_q     <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
      cnt_q     <= cnt_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_umax_reducer.sv
// Scoreboard bench for stream_umax_reducer: default instance plus an IDX_W=4 instance.
module tb_stream_umax_reducer;
  import umax_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv0 = 1'b0, il0 = 1'b0, ordy0 = 1'b0;
  logic [31:0] id0 = '0;
  logic        irdy0, ov0, oovf0;
  logic [31:0] omax0;
  logic [15:0] oidx0, ocnt0;

  logic        iv1 = 1'b0, il1 = 1'b0, ordy1 = 1'b0;
  logic [31:0] id1 = '0;
  logic        irdy1, ov1, oovf1;
  logic [31:0] omax1;
  logic [3:0]  oidx1, ocnt1;

  stream_umax_reducer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(irdy0), .in_data(id0),
    .in_last(il0), .out_valid(ov0), .out_ready(ordy0), .out_max(omax0),
    .out_idx(oidx0), .out_count(ocnt0), .out_ovf(oovf0)
  );

  stream_umax_reducer #(.WIDTH(32), .IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(irdy1), .in_data(id1),
    .in_last(il1), .out_valid(ov1), .out_ready(ordy1), .out_max(omax1),
    .out_idx(oidx1), .out_count(ocnt1), .out_ovf(oovf1)
  );

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode [2] = '{1, 1};   // 0: hold low, 1: hold high, 2: random
  bit bp_done = 1'b0;

  logic [31:0] fr0 [$];
  logic [31:0] fr1 [$];
  red_result_t q0 [$];
  red_result_t q1 [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic die(input string nm);
    miscompares++;
    $display("FAIL %s: timeout waiting on DUT", nm);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bench stopped on timeout");
  endtask

  // Reference: the frame winner under the selected ordering, first occurrence kept.
  function automatic red_result_t summarize(input logic [31:0] f [$], input bit trunc);
    red_result_t r;
    logic [31:0] best;
    int bi;
    best = f[0];
    bi = 0;
    for (int i = 1; i < f.size(); i++) begin
`ifdef UMAX_REDUCER_MIN_EN
      if (f[i] < best) begin best = f[i]; bi = i; end
`else
      if (f[i] > best) begin best = f[i]; bi = i; end
`endif
    end
    r.max   = best;
    r.idx   = IDX_W_DEF'(bi);
    r.count = IDX_W_DEF'(f.size() - 1);
    r.ovf   = trunc;
    return r;
  endfunction

  task automatic model_beat(input int sel, input logic [31:0] d, input bit last);
    if (sel == 0) begin
      fr0.push_back(d);
      if (last || fr0.size() == 65536) begin
        q0.push_back(summarize(fr0, !last));
        fr0.delete();
      end
    end else begin
      fr1.push_back(d);
      if (last || fr1.size() == 16) begin
        q1.push_back(summarize(fr1, !last));
        fr1.delete();
      end
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [31:0] d, input logic l);
    if (sel == 0) begin iv0 = v; id0 = d; il0 = l; end
    else begin iv1 = v; id1 = d; il1 = l; end
  endtask

  task automatic send(input int sel, input logic [31:0] d, input bit last, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        set_in(sel, 1'b0, $urandom, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
      end
    end
    set_in(sel, 1'b1, d, last);
    model_beat(sel, d, last);
    t = 0;
    forever begin
      @(negedge clk);
      if ((sel == 0) ? irdy0 : irdy1) break;
      t++;
      if (t > 3000) die("in_ready");
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_frames(input int sel, input int n, input int maxlen);
    for (int f = 0; f < n; f++) begin
      int len;
      len = $urandom_range(1, maxlen);
      for (int j = 0; j < len; j++)
        send(sel, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 5)), j == len - 1, 1'b1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 5000) die("drain");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      ordy0 = (rdy_mode[0] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[0] == 1);
      ordy1 = (rdy_mode[1] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[1] == 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov0 && ordy0) begin
      if (q0.size() == 0) check("unexpected_result0", 64'(ov0), 64'd0);
      else begin
        red_result_t e;
        e = q0.pop_front();
        check("max0", 64'(omax0), 64'(e.max));
        check("idx0", 64'(oidx0), 64'(e.idx));
        check("count0", 64'(ocnt0), 64'(e.count));
        check("ovf0", 64'(oovf0), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && ordy1) begin
      if (q1.size() == 0) check("unexpected_result4", 64'(ov1), 64'd0);
      else begin
        red_result_t e;
        e = q1.pop_front();
        check("max4", 64'(omax1), 64'(e.max));
        check("idx4", 64'(oidx1), 64'(e.idx));
        check("count4", 64'(ocnt1), 64'(e.count));
        check("ovf4", 64'(oovf1), 64'(e.ovf));
      end
    end
  end

  initial begin
    logic [31:0] hm;
    logic [15:0] hi, hc;
    int t;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(irdy0), 64'd0);
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_out_max", 64'(omax0), 64'd0);
    check("rst_out_idx_count_ovf", {oidx0, ocnt0, oovf0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(irdy0), 64'd1);

    send(0, 32'd5, 1'b0, 1'b0);
    send(0, 32'd9, 1'b0, 1'b0);
    send(0, 32'd3, 1'b0, 1'b0);
    send(0, 32'd9, 1'b0, 1'b0);
    send(0, 32'd1, 1'b1, 1'b0);
    check("latency_out_valid", 64'(ov0), 64'd1);

    send(0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(0, 32'h0000_0000, 1'b1, 1'b0);
    send(0, 32'h8000_0000, 1'b0, 1'b0);
    send(0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    drain();

    // Backpressure: result must freeze and input stays blocked.
    rdy_mode[0] = 0;
    @(posedge clk); #1;
    send(0, 32'd1, 1'b0, 1'b0);
    send(0, 32'd3, 1'b0, 1'b0);
    send(0, 32'd2, 1'b1, 1'b0);
    hm = omax0; hi = oidx0; hc = ocnt0;
    fork
      begin send(0, 32'd42, 1'b1, 1'b0); bp_done = 1'b1; end
    join_none
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", 64'(ov0), 64'd1);
      check("bp_in_ready", 64'(irdy0), 64'd0);
      check("bp_stable", {omax0, oidx0, ocnt0}, {hm, hi, hc});
    end
    rdy_mode[0] = 1;
    @(negedge clk);
    check("bp_release_hold", 64'(irdy0), 64'd0);
    @(negedge clk);
    check("bp_next_ready", 64'(irdy0), 64'd1);
    t = 0;
    while (!bp_done) begin
      @(negedge clk);
      t++;
      if (t > 100) die("bp_send");
    end
    drain();

    // Forced termination at 16 beats on the narrow instance.
    for (int j = 0; j < 20; j++) send(1, $urandom, 1'b0, 1'b0);
    send(1, $urandom, 1'b1, 1'b0);
    drain();

    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    fork
      rand_frames(0, 40, 8);
      rand_frames(1, 30, 20);
    join
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    drain();

    // Reset in the middle of a frame discards it.
    send(0, 32'd11, 1'b0, 1'b0);
    send(0, 32'd12, 1'b0, 1'b0);
    send(0, 32'd13, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    fr0.delete();
    fr1.delete();
    check("midrst_out_valid", 64'(ov0), 64'd0);
    check("midrst_in_ready", 64'(irdy0), 64'd0);
    check("midrst_outputs", {omax0, oidx0, ocnt0, oovf0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 32'd2, 1'b0, 1'b0);
    send(0, 32'd7, 1'b1, 1'b0);
    drain();
    check("final_queue0", 64'(q0.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_umax_reducer.md
Name: stream_umax_reducer

Overview:
- Sequential stage directly downstream of the combinational 32-bit unsigned max(a,b) datapath.
- Consumes a valid/ready stream of words grouped into frames delimited by a last flag.
- Reduces each frame to its maximum word, the beat index of that maximum, and the beat count.
- Emits one result per frame on a valid/ready output port.

Parameters:
- WIDTH, 32, data word width in bits.
- IDX_W, 16, width of the index and count fields; frame length is limited to 2^IDX_W beats.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept an input beat.
- in_data  input  WIDTH  input word.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  frame result present.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  maximum word of the frame.
- out_idx  output  IDX_W  zero-based beat index of the first occurrence of the maximum.
- out_count  output  IDX_W  number of beats in the frame, minus 1.
- out_ovf  output  1  frame was force-terminated at 2^IDX_W beats.

Behaviour:
- Reset (asynchronous, rst_n=0): state goes to IDLE. in_ready=0 while rst_n is low. out_valid=0, out_max=0, out_idx=0, out_count=0, out_ovf=0. Internal accumulator, index and beat counter are cleared.
- A beat transfers when in_valid & in_ready. A result transfers when out_valid & out_ready.
- States:
  - IDLE (in_ready=1): on a transfer, acc<=in_data, best_idx<=0, cnt<=0. Next state is HOLD if in_last, else ACCUM.
  - ACCUM (in_ready=1): on a transfer, cnt<=cnt+1. If in_data > acc (strictly, unsigned), then acc<=in_data and best_idx<=cnt+1. Next state is HOLD when in_last, or when cnt+1 == 2^IDX_W-1 (in that case out_ovf<=~in_last).
  - HOLD (in_ready=0, out_valid=1): outputs are registered copies of acc, best_idx, cnt and ovf. On a result transfer, go to IDLE next cycle with out_valid=0.
- Latency: out_valid asserts the cycle after the last beat transfers. Minimum of 1 bubble cycle between frames (HOLD→IDLE).
- Ties: the first occurrence is kept; out_idx never moves on an equal value.
- Outputs are stable while out_valid=1 and out_ready=0.
- in_valid low during ACCUM: state holds, no change.
- in_data/in_last are ignored when no transfer occurs.
- Single-beat frame: out_max=in_data, out_idx=0, out_count=0.
- Reset mid-frame or in HOLD: the partial frame or pending result is discarded; no result is emitted.
- All outputs come from registers; there is no combinational in→out path.

Optional Feature:
- Macro: UMAX_REDUCER_MIN_EN.
- Defined: the comparison is inverted to strict unsigned less-than, so the block reports the frame minimum and the index of its first occurrence. All other behaviour is unchanged.
- Undefined: maximum, as above.

Decomposition:
- Package umax_pkg holds:
  - WIDTH_DEF=32 and IDX_W_DEF=16.
  - State enum red_state_e {IDLE, ACCUM, HOLD}.
  - Result struct red_result_t {max, idx, count, ovf}.
- One sub-module: umax_cmp, a purely combinational (a, b) → (gt, sel_val) WIDTH-bit comparator. It reuses the prefix-compare structure of the existing max datapath; under UMAX_REDUCER_MIN_EN it swaps its operands. The reducer instantiates it once, with acc and in_data as operands.

Test Plan:
- Frame 5, 9, 3, 9, 1 with last on the 5th beat, out_ready=1 → one result: out_max=9, out_idx=1, out_count=4, out_ovf=0. out_valid is high exactly 1 cycle after the last beat.
- Single beat 0xFFFFFFFF with last → out_max=0xFFFFFFFF, out_idx=0, out_count=0. Then beat 0x00000000 with last → out_max=0, out_idx=0.
- Unsigned check: frame 0x80000000, 0x7FFFFFFF → out_max=0x80000000, out_idx=0. With UMAX_REDUCER_MIN_EN → out_max=0x7FFFFFFF, out_idx=1.
- Backpressure: hold out_ready=0 for 10 cycles after the result appears → out_valid stays 1, fields stay constant, in_ready=0 throughout. Release → next frame accepted 1 cycle later.
- IDX_W=4, 20 beats without last → result after beat 16 with out_count=15 and out_ovf=1. The remaining 4 beats form a new frame.
- Assert rst_n=0 mid-frame after 3 beats → out_valid=0 and all outputs 0 immediately. After release, a fresh frame 2, 7 with last → out_max=7, out_idx=1, out_count=1.
